// File: rtl/dm_cdc_src_fifo.sv
// Source-side feeder FIFO for the clearable 2-phase CDC.
// Queues requests and sequences local clears against the CDC handshake.
module dm_cdc_src_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  output logic                  busy_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [DATA_WIDTH-1:0] cdc_data_o,
  output logic                  cdc_valid_o,
  input  logic                  cdc_ready_i,
  output logic                  cdc_clear_o,
  input  logic                  cdc_clear_pending_i,
  output logic [$clog2(DEPTH):0] usage_o
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("dm_cdc_src_fifo: DEPTH must be a power of two >= 2");
  end

  typedef enum logic [1:0] {
    RUN,
    CLR,
    WAIT_RISE,
    WAIT_FALL
  } state_e;

  state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W:0]       wr_ptr_q, rd_ptr_q;
  logic                  full, empty;
  logic                  push, pop;
  logic                  run;

  assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                 (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign run   = (state_q == RUN);

  // A clear request already suppresses traffic in the RUN cycle it arrives.
  assign in_ready_o  = !full && run && !clear_i;
  assign cdc_valid_o = !empty && run && !cdc_clear_pending_i && !clear_i;
  assign cdc_data_o  = mem[rd_ptr_q[ADDR_W-1:0]];

  assign push = in_valid_i && in_ready_o;
  assign pop  = cdc_valid_o && cdc_ready_i;

  assign usage_o = wr_ptr_q - rd_ptr_q;
  assign busy_o  = !run;

  always_comb begin
    state_d     = state_q;
    cdc_clear_o = 1'b0;
    unique case (state_q)
      RUN: begin
        if (clear_i) state_d = CLR;
      end
      CLR: begin
        cdc_clear_o = 1'b1;
        state_d     = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (cdc_clear_pending_i) state_d = WAIT_FALL;
      end
      WAIT_FALL: begin
        if (!cdc_clear_pending_i) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (state_q == CLR) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q[ADDR_W-1:0]] <= in_data_i;
  end

  a_no_clear_valid: assert property (
    @(posedge clk_i) disable iff (!rst_ni) !(cdc_clear_o && cdc_valid_o));
  a_clear_single: assert property (
    @(posedge clk_i) disable iff (!rst_ni) cdc_clear_o |=> !cdc_clear_o);
  a_usage_max: assert property (
    @(posedge clk_i) disable iff (!rst_ni) usage_o <= (ADDR_W+1)'(DEPTH));
  a_no_push_full: assert property (
    @(posedge clk_i) disable iff (!rst_ni) !(push && full));
  a_no_pop_empty: assert property (
    @(posedge clk_i) disable iff (!rst_ni) !(pop && empty));

endmodule

// File: tb/tb_dm_cdc_src_fifo.sv
// Scoreboard bench for dm_cdc_src_fifo.
// Inputs change at negedge; outputs sampled 1ns later.
module tb_dm_cdc_src_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);

  logic          clk;
  logic          rst_n;
  logic          clear;
  logic          busy;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] cdc_data;
  logic          cdc_valid;
  logic          cdc_ready;
  logic          cdc_clear;
  logic          pending;
  logic [AW:0]   usage;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] sb [$];
  logic          last_push;
  logic          last_pop;

  dm_cdc_src_fifo #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .clear_i            (clear),
    .busy_o             (busy),
    .in_data_i          (in_data),
    .in_valid_i         (in_valid),
    .in_ready_o         (in_ready),
    .cdc_data_o         (cdc_data),
    .cdc_valid_o        (cdc_valid),
    .cdc_ready_i        (cdc_ready),
    .cdc_clear_o        (cdc_clear),
    .cdc_clear_pending_i(pending),
    .usage_o            (usage)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Sample, score handshakes, then advance to the next negedge.
  task automatic tick();
    logic [DW-1:0] exp;
    #1;
    last_push = in_valid && in_ready;
    last_pop  = cdc_valid && cdc_ready;
    checks++;
    if (cdc_clear && cdc_valid) begin
      failures++;
      $display("FAIL clear_with_valid got=1 expected=0");
    end
    if (last_pop) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL pop_unexpected got=%h expected=none", cdc_data);
      end else begin
        exp = sb.pop_front();
        if (cdc_data !== exp) begin
          failures++;
          $display("FAIL pop_data got=%h expected=%h", cdc_data, exp);
        end
      end
    end
    if (last_push) sb.push_back(in_data);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    clear    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    cdc_ready = 1'b0;
    pending  = 1'b0;
  endtask

  task automatic drain(input string name);
    in_valid  = 1'b0;
    cdc_ready = 1'b1;
    for (int c = 0; c < 30 && sb.size() != 0; c++) tick();
    checks++;
    if (sb.size() != 0 || usage !== '0) begin
      failures++;
      $display("FAIL %s_drain left=%0d usage=%0d expected=0", name, sb.size(), usage);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    sb.delete();
    #1;
    checks++;
    if (usage !== '0 || in_ready !== 1'b1 || cdc_valid !== 1'b0 ||
        cdc_clear !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got=u%0d r%b v%b c%b b%b expected=u0 r1 v0 c0 b0",
               usage, in_ready, cdc_valid, cdc_clear, busy);
    end
    @(negedge clk);
  endtask

  task automatic test_stream();
    logic [DW-1:0] w [4];
    w[0] = 32'h11; w[1] = 32'h22; w[2] = 32'h33; w[3] = 32'h44;
    cdc_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = w[i];
      if (i == 0) begin
        #1;
        checks++;
        if (cdc_valid !== 1'b0) begin
          failures++;
          $display("FAIL stream_no_fallthrough got=%b expected=0", cdc_valid);
        end
        #0;
      end
      tick();
      if (i == 0) begin
        #1;
        checks++;
        if (cdc_valid !== 1'b1 || cdc_data !== 32'h11) begin
          failures++;
          $display("FAIL stream_first_latency got=v%b d%h expected=v1 d11",
                   cdc_valid, cdc_data);
        end
      end
    end
    drain("stream");
  endtask

  task automatic test_backpressure();
    int k = 0;
    cdc_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1;
      in_data  = 32'hA0 + k;
      tick();
      if (last_push) k++;
    end
    #1;
    checks++;
    if (k != DEPTH || usage !== 3'd4 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_full got=k%0d u%0d r%b expected=k4 u4 r0", k, usage, in_ready);
    end
    @(negedge clk);
    cdc_ready = 1'b1;
    for (int c = 0; c < 10 && k < 5; c++) begin
      tick();
      if (last_push) k++;
    end
    checks++;
    if (k != 5) begin
      failures++;
      $display("FAIL bp_fifth_push got=%0d expected=5", k);
    end
    drain("bp");
  endtask

  task automatic test_local_clear();
    cdc_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hC0 + i;
      tick();
    end
    in_valid = 1'b0;
    clear    = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0 || cdc_valid !== 1'b0) begin
      failures++;
      $display("FAIL lc_request_cycle got=r%b v%b expected=r0 v0", in_ready, cdc_valid);
    end
    #0;
    tick();
    clear = 1'b0;
    #1;
    checks++;
    if (cdc_clear !== 1'b1 || cdc_valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL lc_clr_cycle got=c%b v%b b%b expected=c1 v0 b1",
               cdc_clear, cdc_valid, busy);
    end
    tick();
    sb.delete();
    #1;
    checks++;
    if (usage !== '0 || cdc_clear !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL lc_after_clr got=u%0d c%b b%b expected=u0 c0 b1",
               usage, cdc_clear, busy);
    end
    tick();
    pending = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL lc_pending_busy got=b%b r%b expected=b1 r0", busy, in_ready);
      end
      #0;
      tick();
    end
    pending = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL lc_fall_cycle got=b%b r%b expected=b1 r0", busy, in_ready);
    end
    tick();
    #1;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || usage !== '0) begin
      failures++;
      $display("FAIL lc_resume got=b%b r%b u%0d expected=b0 r1 u0", busy, in_ready, usage);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'hC5;
    tick();
    drain("lc");
  endtask

  task automatic test_remote_clear();
    cdc_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hD0 + i;
      tick();
    end
    in_valid  = 1'b0;
    pending   = 1'b1;
    cdc_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (cdc_valid !== 1'b0 || usage !== 3'd2 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL rc_hold got=v%b u%0d r%b expected=v0 u2 r1",
                 cdc_valid, usage, in_ready);
      end
      #0;
      tick();
    end
    pending = 1'b0;
    drain("rc");
  endtask

  task automatic test_clear_held();
    int pulses = 0;
    clear = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (cdc_clear === 1'b1) pulses++;
    end
    clear   = 1'b0;
    pending = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (cdc_clear === 1'b1) pulses++;
      tick();
    end
    pending = 1'b0;
    for (int i = 0; i < 10 && busy !== 1'b0; i++) begin
      if (cdc_clear === 1'b1) pulses++;
      tick();
    end
    sb.delete();
    checks++;
    if (pulses != 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL clear_held_pulses got=%0d busy=%b expected=1 busy=0", pulses, busy);
    end
  endtask

  task automatic test_reset_mid();
    cdc_ready = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    sb.delete();
    pending = 1'b1;
    tick();
    #1;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL rm_in_wait_fall got=%b expected=1", busy);
    end
    #0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || usage !== '0 || in_ready !== 1'b1 || cdc_valid !== 1'b0) begin
      failures++;
      $display("FAIL rm_after_reset got=b%b u%0d r%b v%b expected=b0 u0 r1 v0",
               busy, usage, in_ready, cdc_valid);
    end
    @(negedge clk);
    pending = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    int n = 3 * DEPTH + 1;
    int sent = 0;
    int got = 0;
    for (int c = 0; c < 600 && !(sent == n && sb.size() == 0); c++) begin
      in_valid  = (sent < n) && ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      cdc_ready = ($urandom_range(0, 2) != 0);
      tick();
      if (last_push) sent++;
      if (last_pop) got++;
    end
    in_valid = 1'b0;
    checks++;
    if (sent != n || got != n || sb.size() != 0 || usage !== '0) begin
      failures++;
      $display("FAIL wrap_count got=sent%0d popped%0d left%0d expected=%0d/%0d/0",
               sent, got, sb.size(), n, n);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_local_clear();
    test_remote_clear();
    test_clear_held();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
